// File: rtl/alu_decode_exec.sv
// Decode-and-execute stage of the single-cycle RISC-V datapath: main control,
// ALU control and the ALU itself, with every output registered once.
module alu_decode_exec (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrucao,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic        ALUSrc,
    output logic        MemoriaMov,
    output logic        RegistradorEsc,
    output logic        MemoriaLida,
    output logic        MemoriaEscrita,
    output logic        Branch,
    output logic        ALUOp1,
    output logic        ALUOp0,
    output logic [3:0]  ALUcontrol,
    output logic [31:0] ALU_Out,
    output logic        Zero
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        unused_instr_bits;

    assign opcode            = instrucao[6:0];
    assign funct3            = instrucao[14:12];
    assign funct7_b5         = instrucao[30];
    assign unused_instr_bits = ^{instrucao[31], instrucao[29:15], instrucao[11:7]};

    // Packed as {ALUSrc, MemoriaMov, RegistradorEsc, MemoriaLida, MemoriaEscrita, Branch, ALUOp[1:0]}
    logic [7:0]  ctrl_d;
    logic [3:0]  alu_ctrl_d;
    logic [31:0] result_d;

    always_comb begin
        ctrl_d = 8'b0000_0000;
        case (opcode)
            7'b0110011: ctrl_d = 8'b0010_0010;
            7'b0010011: ctrl_d = 8'b1010_0011;
            7'b0000011: ctrl_d = 8'b1111_0000;
            7'b0100011: ctrl_d = 8'b1000_1000;
            7'b1100011: ctrl_d = 8'b0000_0101;
            default:    ctrl_d = 8'b0000_0000;
        endcase
    end

    always_comb begin
        alu_ctrl_d = OP_ADD;
        case (ctrl_d[1:0])
            2'b00: alu_ctrl_d = OP_ADD;
            2'b01: alu_ctrl_d = OP_SUB;
            default: begin
                // I-type has no SUBI, so bit 30 only matters for R-type funct3 000
                case (funct3)
                    3'b000: alu_ctrl_d = (ctrl_d[1:0] == 2'b10 && funct7_b5) ? OP_SUB : OP_ADD;
                    3'b001: alu_ctrl_d = OP_SLL;
                    3'b010: alu_ctrl_d = OP_SLT;
                    3'b011: alu_ctrl_d = OP_SLTU;
                    3'b100: alu_ctrl_d = OP_XOR;
                    3'b101: alu_ctrl_d = funct7_b5 ? OP_SRA : OP_SRL;
                    3'b110: alu_ctrl_d = OP_OR;
                    default: alu_ctrl_d = OP_AND;
                endcase
            end
        endcase
    end

    always_comb begin
        result_d = 32'd0;
        case (alu_ctrl_d)
            OP_AND:  result_d = data1 & data2;
            OP_OR:   result_d = data1 | data2;
            OP_ADD:  result_d = data1 + data2;
            OP_XOR:  result_d = data1 ^ data2;
            OP_SLL:  result_d = data1 << data2[4:0];
            OP_SRL:  result_d = data1 >> data2[4:0];
            OP_SUB:  result_d = data1 - data2;
            OP_SLT:  result_d = {31'd0, $signed(data1) < $signed(data2)};
            OP_SRA:  result_d = $unsigned($signed(data1) >>> data2[4:0]);
            OP_SLTU: result_d = {31'd0, data1 < data2};
            default: result_d = 32'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ALUSrc         <= 1'b0;
            MemoriaMov     <= 1'b0;
            RegistradorEsc <= 1'b0;
            MemoriaLida    <= 1'b0;
            MemoriaEscrita <= 1'b0;
            Branch         <= 1'b0;
            ALUOp1         <= 1'b0;
            ALUOp0         <= 1'b0;
            ALUcontrol     <= 4'd0;
            ALU_Out        <= 32'd0;
            Zero           <= 1'b0;
        end else begin
            ALUSrc         <= ctrl_d[7];
            MemoriaMov     <= ctrl_d[6];
            RegistradorEsc <= ctrl_d[5];
            MemoriaLida    <= ctrl_d[4];
            MemoriaEscrita <= ctrl_d[3];
            Branch         <= ctrl_d[2];
            ALUOp1         <= ctrl_d[1];
            ALUOp0         <= ctrl_d[0];
            ALUcontrol     <= alu_ctrl_d;
            ALU_Out        <= result_d;
            Zero           <= (result_d == 32'd0);
        end
    end

endmodule

// File: tb/tb_alu_decode_exec.sv
// Bench for alu_decode_exec: directed vectors drive a scoreboard queue that a
// monitor drains one entry per clock edge after the registered outputs settle.
module tb_alu_decode_exec;

    logic        clock;
    logic        reset;
    logic [31:0] instrucao;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        ALUSrc, MemoriaMov, RegistradorEsc, MemoriaLida;
    logic        MemoriaEscrita, Branch, ALUOp1, ALUOp0;
    logic [3:0]  ALUcontrol;
    logic [31:0] ALU_Out;
    logic        Zero;

    alu_decode_exec dut (
        .clock          (clock),
        .reset          (reset),
        .instrucao      (instrucao),
        .data1          (data1),
        .data2          (data2),
        .ALUSrc         (ALUSrc),
        .MemoriaMov     (MemoriaMov),
        .RegistradorEsc (RegistradorEsc),
        .MemoriaLida    (MemoriaLida),
        .MemoriaEscrita (MemoriaEscrita),
        .Branch         (Branch),
        .ALUOp1         (ALUOp1),
        .ALUOp0         (ALUOp0),
        .ALUcontrol     (ALUcontrol),
        .ALU_Out        (ALU_Out),
        .Zero           (Zero)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    // Expected word: {ctrl[7:0], ALUcontrol[3:0], ALU_Out[31:0], Zero}
    logic [44:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Control byte order: ALUSrc, MemoriaMov, RegistradorEsc, MemoriaLida, MemoriaEscrita, Branch, ALUOp1, ALUOp0
    localparam logic [7:0] C_R  = 8'h22;
    localparam logic [7:0] C_I  = 8'hA3;
    localparam logic [7:0] C_LD = 8'hF0;
    localparam logic [7:0] C_ST = 8'h88;
    localparam logic [7:0] C_BR = 8'h05;
    localparam logic [7:0] C_NO = 8'h00;

    function automatic logic [44:0] actual_vec();
        return {ALUSrc, MemoriaMov, RegistradorEsc, MemoriaLida, MemoriaEscrita,
                Branch, ALUOp1, ALUOp0, ALUcontrol, ALU_Out, Zero};
    endfunction

    task automatic check_vec(input string name, input logic [44:0] act, input logic [44:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got ctrl=%02h aluc=%h out=%08h z=%b, want ctrl=%02h aluc=%h out=%08h z=%b",
                      name, act[44:37], act[36:33], act[32:1], act[0],
                      exp[44:37], exp[36:33], exp[32:1], exp[0]);
    endtask

    // Monitor: outputs are valid every cycle; pop one expectation per edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) check_vec(name_q.pop_front(), actual_vec(), exp_q.pop_front());
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input string name, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [7:0] ctrl, input logic [3:0] aluc,
                         input logic [31:0] res, input logic z);
        @(negedge clock);
        instrucao = ins;
        data1     = a;
        data2     = b;
        exp_q.push_back({ctrl, aluc, res, z});
        name_q.push_back(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b0;
        instrucao = 32'h00208033;
        data1     = 32'd5;
        data2     = 32'd7;
        #3;
        check_vec("reset_async", actual_vec(), 45'd0);
        @(posedge clock);
        #1;
        check_vec("reset_hold_edge", actual_vec(), 45'd0);
        @(negedge clock);
        reset = 1'b1;

        drive("add",       32'h00208033, 32'd5,       32'd7,      C_R,  4'b0010, 32'd12,       1'b0);
        drive("sub_zero",  32'h40208033, 32'h1234,    32'h1234,   C_R,  4'b0110, 32'd0,        1'b1);
        drive("sub_wrap",  32'h40208033, 32'd0,       32'd1,      C_R,  4'b0110, 32'hFFFFFFFF, 1'b0);
        drive("load",      32'h0080A083, 32'h100,     32'd8,      C_LD, 4'b0010, 32'h108,      1'b0);
        drive("store",     32'h0020A423, 32'h100,     32'd8,      C_ST, 4'b0010, 32'h108,      1'b0);
        drive("beq_taken", 32'h00208063, 32'd9,       32'd9,      C_BR, 4'b0110, 32'd0,        1'b1);
        drive("beq_not",   32'h00208063, 32'd9,       32'd8,      C_BR, 4'b0110, 32'd1,        1'b0);
        drive("and",       32'h0020F033, 32'hF0F0,    32'hFF00,   C_R,  4'b0000, 32'hF000,     1'b0);
        drive("or",        32'h0020E033, 32'hF0F0,    32'hFF00,   C_R,  4'b0001, 32'hFFF0,     1'b0);
        drive("sra",       32'h4020D033, 32'h80000000, 32'd4,     C_R,  4'b1000, 32'hF8000000, 1'b0);
        drive("srl",       32'h0020D033, 32'h80000000, 32'd4,     C_R,  4'b0101, 32'h08000000, 1'b0);
        drive("slt",       32'h0020A033, 32'hFFFFFFFF, 32'd1,     C_R,  4'b0111, 32'd1,        1'b0);
        drive("sltu",      32'h0020B033, 32'hFFFFFFFF, 32'd1,     C_R,  4'b1001, 32'd0,        1'b1);
        drive("xor",       32'h0020C033, 32'hFF00,    32'h0FF0,   C_R,  4'b0011, 32'hF0F0,     1'b0);
        drive("sll_mask",  32'h00209033, 32'd1,       32'h23,     C_R,  4'b0100, 32'd8,        1'b0);
        drive("addi_b30",  32'h40008013, 32'd10,      32'd3,      C_I,  4'b0010, 32'd13,       1'b0);
        drive("srai",      32'h4000D013, 32'h80000000, 32'd4,     C_I,  4'b1000, 32'hF8000000, 1'b0);
        drive("slti",      32'h0000A013, 32'hFFFFFFFB, 32'hFFFFFFFE, C_I, 4'b0111, 32'd1,      1'b0);
        drive("unknown",   32'h0000007F, 32'd3,       32'd4,      C_NO, 4'b0010, 32'd7,        1'b0);

        // Mid-operation reset between edges: outputs must clear without a clock edge.
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_vec("reset_mid", actual_vec(), 45'd0);
        @(posedge clock);
        #2;
        check_vec("reset_mid_edge", actual_vec(), 45'd0);
        reset = 1'b1;

        drive("post_reset", 32'h40208033, 32'd20, 32'd5, C_R, 4'b0110, 32'd15, 1'b0);
        drive("post_and",   32'h0020F033, 32'h0F,  32'hF0, C_R, 4'b0000, 32'd0,  1'b1);

        // Input change between edges must not leak to the outputs.
        @(posedge clock);
        #1;
        @(negedge clock);
        instrucao = 32'h0020E033;
        data1     = 32'hAAAA;
        #2;
        check_vec("hold_between_edges", actual_vec(), {C_R, 4'b0000, 32'd0, 1'b1});

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
